id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures the decode-stage instruction bundle on each rising clk edge and
// presents it to the execute stage. Forwarding muxes for operands A, B and
// store data sit after the registers, so late forwarding data reaches the
// ALU in the same cycle without ever being stored.
//
// Control semantics (single place they are described):
//   reset : synchronous, highest priority; clears every registered field.
//   flush : next priority; captures a bubble (all fields zero), overriding stall.
//   stall : holds every registered field, including Tnew (no countdown).
//   none  : loads the D-stage bundle; D->E latency is exactly one cycle.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        D_valid,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [31:0] D_imm32,
  input  logic [2:0]  D_ALU_op,
  input  logic        D_ALUSrc,
  input  logic        D_RegWrite,
  input  logic [4:0]  D_A3,
  input  logic [1:0]  D_Tnew,
  input  logic [1:0]  fwd_A_sel,
  input  logic [1:0]  fwd_B_sel,
  input  logic [31:0] M_fwd_data,
  input  logic [31:0] W_fwd_data,
  output logic        E_valid,
  output logic [31:0] E_PC,
  output logic [31:0] E_instr,
  output logic [31:0] E_A,
  output logic [31:0] E_B,
  output logic [31:0] E_rt_fwd,
  output logic [2:0]  E_ALU_op,
  output logic        E_RegWrite,
  output logic [4:0]  E_A3,
  output logic [1:0]  E_Tnew
);

  // Registered E-stage fields
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic [31:0] imm_q;
  logic [2:0]  alu_op_q;
  logic        alusrc_q;
  logic        regwrite_q;
  logic [4:0]  a3_q;
  logic [1:0]  tnew_q;

  // Values as they will be captured on a load
  logic        cap_regwrite;
  logic [4:0]  cap_a3;
  logic [1:0]  cap_tnew;

  // A write to $0 (or from an invalid slot) is never advertised, and the
  // destination is zeroed so hazard logic cannot match on a stale A3.
  always_comb begin
    cap_regwrite = D_RegWrite && (D_A3 != 5'd0) && D_valid;
    cap_a3       = cap_regwrite ? D_A3 : 5'd0;
    cap_tnew     = (D_Tnew == 2'd0) ? 2'd0 : (D_Tnew - 2'd1);
  end

  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      alu_op_q   <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      tnew_q     <= '0;
    end else if (!stall) begin
      valid_q    <= D_valid;
      pc_q       <= D_PC;
      instr_q    <= D_instr;
      rs_q       <= D_rs_data;
      rt_q       <= D_rt_data;
      imm_q      <= D_imm32;
      alu_op_q   <= D_ALU_op;
      alusrc_q   <= D_ALUSrc;
      regwrite_q <= cap_regwrite;
      a3_q       <= cap_a3;
      tnew_q     <= cap_tnew;
    end
  end

  // Operand forwarding: selects 0 and 3 both pass the registered value
  always_comb begin
    E_A = rs_q;
    case (fwd_A_sel)
      2'd1:    E_A = M_fwd_data;
      2'd2:    E_A = W_fwd_data;
      default: E_A = rs_q;
    endcase
    E_rt_fwd = rt_q;
    case (fwd_B_sel)
      2'd1:    E_rt_fwd = M_fwd_data;
      2'd2:    E_rt_fwd = W_fwd_data;
      default: E_rt_fwd = rt_q;
    endcase
    E_B = alusrc_q ? imm_q : E_rt_fwd;
  end

  // Remaining outputs come straight from registers
  assign E_valid    = valid_q;
  assign E_PC       = pc_q;
  assign E_instr    = instr_q;
  assign E_ALU_op   = alu_op_q;
  assign E_RegWrite = regwrite_q;
  assign E_A3       = a3_q;
  assign E_Tnew     = tnew_q;

endmodule
